// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit and its call stack.
package instr_fetch_unit_pkg;

    localparam int unsigned PC_W        = 13;
    localparam int unsigned INSTR_W     = 14;
    localparam int unsigned STACK_DEPTH = 8;
    localparam int unsigned PCLATH_W    = 5;
    localparam int unsigned PCL_W       = 8;

    localparam logic [INSTR_W-1:0] NOP_WORD = 14'h0000;

    typedef enum logic [1:0] {
        StkHold,
        StkPush,
        StkPop,
        StkIllegal
    } stack_op_e;

    // Push and pop together is illegal; the stack flags it instead of moving.
    function automatic stack_op_e stack_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = StkPush;
            2'b01:   op = StkPop;
            2'b11:   op = StkIllegal;
            default: op = StkHold;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_call_stack.sv
// Circular hardware call stack with saturating live count and sticky error flags.
module instr_fetch_unit_call_stack
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned WIDTH = PC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_en,
    input  logic             pop_en,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam int unsigned SpW = $clog2(DEPTH);

    logic [SpW-1:0]   sp_q;
    logic [SpW-1:0]   sp_dec;
    logic [SpW:0]     count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    stack_op_e        op;

    assign op     = stack_op(push_en, pop_en);
    assign sp_dec = sp_q - SpW'(1);
    assign top    = mem_q[sp_dec];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q      <= '0;
            count_q   <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            unique case (op)
                StkPush: begin
                    sp_q <= sp_q + SpW'(1);
                    if (count_q == (SpW+1)'(DEPTH)) stack_ovf <= 1'b1;
                    else                            count_q   <= count_q + (SpW+1)'(1);
                end
                StkPop: begin
                    sp_q <= sp_dec;
                    if (count_q == '0) stack_unf <= 1'b1;
                    else               count_q   <= count_q - (SpW+1)'(1);
                end
                StkIllegal: begin
                    stack_ovf <= 1'b1;
                    stack_unf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Contents are not reset; a push coinciding with reset must not land.
    always_ff @(posedge clk) begin
        if (!rst && op == StkPush) mem_q[sp_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction register and call stack feeding the decoder.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned       PC_WIDTH     = PC_W,
    parameter int unsigned       INSTR_WIDTH  = INSTR_W,
    parameter int unsigned       STACK_DEPTH  = instr_fetch_unit_pkg::STACK_DEPTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_WIDTH-1:0]    prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr_current,
    input  logic                   instr_rd_en,
    input  logic                   instr_flush,
    input  logic                   pc_incr_en,
    input  logic                   pc_j_en,
    input  logic                   push_en,
    input  logic                   pop_en,
    input  logic [PCLATH_W-1:0]    pclath,
    input  logic                   pcl_wr_en,
    input  logic [PCL_W-1:0]       pcl_wr_data,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   stack_ovf,
    output logic                   stack_unf
);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    stack_top;
    logic [INSTR_WIDTH-1:0] instr_q;

    assign prog_addr     = pc_q;
    assign pc_out        = pc_q;
    assign instr_current = instr_q;

    instr_fetch_unit_call_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_call_stack (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .pop_en    (pop_en),
        .push_data (pc_q),
        .top       (stack_top),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    always_comb begin
        pc_d = pc_q;
        if (pcl_wr_en) begin
            pc_d = PC_WIDTH'({pclath, pcl_wr_data});
        end else if (pop_en) begin
            pc_d = stack_top;
        end else if (pc_j_en) begin
            pc_d = PC_WIDTH'({pclath[4:3], instr_q[10:0]});
        end else if (pc_incr_en) begin
            pc_d = pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            instr_q <= INSTR_WIDTH'(NOP_WORD);
        end else begin
            pc_q <= pc_d;
            if (instr_flush)      instr_q <= INSTR_WIDTH'(NOP_WORD);
            else if (instr_rd_en) instr_q <= prog_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized check of instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] prog_addr;
    logic [13:0] prog_data;
    logic [13:0] instr_current;
    logic        instr_rd_en = 0, instr_flush = 0, pc_incr_en = 0, pc_j_en = 0;
    logic        push_en = 0, pop_en = 0, pcl_wr_en = 0;
    logic [4:0]  pclath = '0;
    logic [7:0]  pcl_wr_data = '0;
    logic [12:0] pc_out;
    logic        stack_ovf, stack_unf;

    logic [13:0] rom [8192];

    int n_checks = 0;
    int n_err    = 0;
    bit checking = 0;

    // Model state
    int m_pc, m_instr, m_sp, m_cnt;
    int m_mem [8];
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    assign prog_data = rom[prog_addr];

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .instr_current (instr_current),
        .instr_rd_en   (instr_rd_en),
        .instr_flush   (instr_flush),
        .pc_incr_en    (pc_incr_en),
        .pc_j_en       (pc_j_en),
        .push_en       (push_en),
        .pop_en        (pop_en),
        .pclath        (pclath),
        .pcl_wr_en     (pcl_wr_en),
        .pcl_wr_data   (pcl_wr_data),
        .pc_out        (pc_out),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Next state straight from the behaviour rules, using the inputs of this cycle.
    task automatic model_step();
        int top, nxt_pc;
        top = m_mem[(m_sp + 7) % 8];
        if (pcl_wr_en)       nxt_pc = (int'(pclath) << 8) | int'(pcl_wr_data);
        else if (pop_en)     nxt_pc = top;
        else if (pc_j_en)    nxt_pc = ((int'(pclath) >> 3) << 11) | (m_instr % 2048);
        else if (pc_incr_en) nxt_pc = (m_pc + 1) % 8192;
        else                 nxt_pc = m_pc;
        if (push_en && pop_en) begin
            m_ovf = 1; m_unf = 1;
        end else if (push_en) begin
            m_mem[m_sp] = m_pc;
            m_sp = (m_sp + 1) % 8;
            if (m_cnt == 8) m_ovf = 1; else m_cnt++;
        end else if (pop_en) begin
            m_sp = (m_sp + 7) % 8;
            if (m_cnt == 0) m_unf = 1; else m_cnt--;
        end
        if (instr_flush)      m_instr = 0;
        else if (instr_rd_en) m_instr = int'(rom[m_pc]);
        m_pc = nxt_pc;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
        push_en = 0; pop_en = 0; pcl_wr_en = 0;
    endtask

    task automatic set_pc(input int v);
        idle_inputs();
        pcl_wr_en = 1; pclath = 5'(v >> 8); pcl_wr_data = 8'(v);
        step();
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1; model_reset();
        step();
        rst = 0;
    endtask

    always @(negedge clk) begin
        if (checking && !rst) begin
            chk("prog_addr", 32'(prog_addr), 32'(m_pc));
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("instr_current", 32'(instr_current), 32'(m_instr));
            chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
            chk("stack_unf", 32'(stack_unf), 32'(m_unf));
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) rom[i] = 14'(i + 1);
        rom[2]    = 14'h2923;  // GOTO 0x123
        rom[13'h44] = 14'h2200; // CALL 0x200
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
        model_reset();

        // Reset state
        #3;
        chk("reset pc", 32'(pc_out), 32'h0);
        chk("reset instr", 32'(instr_current), 32'h0);
        chk("reset flags", 32'({stack_ovf, stack_unf}), 32'h0);
        @(negedge clk);
        rst = 0;
        checking = 1;

        // 1: fetch every 4th cycle
        for (int k = 0; k < 8; k++) begin
            instr_rd_en = (k % 4 == 0);
            pc_incr_en  = (k % 4 == 0);
            step();
            if (k == 0) begin
                chk("t1 instr a", 32'(instr_current), 32'h1);
                chk("t1 pc a", 32'(pc_out), 32'h1);
            end
        end
        idle_inputs();
        chk("t1 instr b", 32'(instr_current), 32'h2);
        chk("t1 pc b", 32'(pc_out), 32'h2);

        // 2: GOTO with PCLATH high bits
        instr_rd_en = 1; pc_incr_en = 1; step(); idle_inputs();
        chk("t2 goto latched", 32'(instr_current), 32'h2923);
        pclath = 5'b11000; pc_j_en = 1; instr_flush = 1; step(); idle_inputs();
        chk("t2 pc", 32'(pc_out), 32'h1923);
        chk("t2 instr", 32'(instr_current), 32'h0);

        // 3: CALL / RETURN
        pclath = 0; set_pc(13'h44);
        instr_rd_en = 1; pc_incr_en = 1; step(); idle_inputs();
        chk("t3 pc before call", 32'(pc_out), 32'h45);
        push_en = 1; pc_j_en = 1; instr_flush = 1; step(); idle_inputs();
        chk("t3 call target", 32'(pc_out), 32'h200);
        pc_incr_en = 1; step(); step(); idle_inputs();
        pop_en = 1; instr_flush = 1; step(); idle_inputs();
        chk("t3 return", 32'(pc_out), 32'h45);

        // 4: overflow and underflow
        set_pc(13'h10);
        for (int i = 0; i < 9; i++) begin
            push_en = 1; pc_incr_en = 1; step();
        end
        idle_inputs();
        chk("t4 ovf", 32'(stack_ovf), 32'h1);
        chk("t4 no unf", 32'(stack_unf), 32'h0);
        for (int i = 0; i < 8; i++) begin
            pop_en = 1; step();
            chk("t4 pop value", 32'(pc_out), 32'(8'h18 - i));
        end
        chk("t4 no unf yet", 32'(stack_unf), 32'h0);
        step(); idle_inputs();
        chk("t4 unf", 32'(stack_unf), 32'h1);

        // 5: PCL write beats increment; increment wraps
        pclath = 5'h02; pcl_wr_data = 8'h7F; pcl_wr_en = 1; pc_incr_en = 1; step(); idle_inputs();
        chk("t5 pcl write", 32'(pc_out), 32'h027F);
        set_pc(13'h1FFF);
        pc_incr_en = 1; step(); idle_inputs();
        chk("t5 wrap", 32'(pc_out), 32'h0);

        // 6: asynchronous reset in the middle of a CALL
        set_pc(13'h345);
        push_en = 1; pc_j_en = 1; instr_flush = 1;
        #2;
        rst = 1; model_reset();
        #1;
        chk("t6 pc", 32'(pc_out), 32'h0);
        chk("t6 instr", 32'(instr_current), 32'h0);
        chk("t6 ovf", 32'(stack_ovf), 32'h0);
        chk("t6 unf", 32'(stack_unf), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 0; idle_inputs();
        pop_en = 1; step(); idle_inputs();
        chk("t6 count cleared", 32'(stack_unf), 32'h1);
        do_reset();

        // Randomized phase
        for (int i = 0; i < 8192; i++) rom[i] = 14'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                idle_inputs();
                do_reset();
            end else begin
                instr_rd_en = ($urandom_range(0, 99) < 50);
                instr_flush = ($urandom_range(0, 99) < 15);
                pc_incr_en  = ($urandom_range(0, 99) < 60);
                pc_j_en     = ($urandom_range(0, 99) < 15);
                push_en     = ($urandom_range(0, 99) < 15);
                pop_en      = ($urandom_range(0, 99) < 15);
                pcl_wr_en   = ($urandom_range(0, 99) < 10);
                pclath      = 5'($urandom);
                pcl_wr_data = 8'($urandom);
                if (push_en && pop_en && $urandom_range(0, 49) != 0) pop_en = 0;
                step();
            end
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
